// File: rtl/rom_dl_sequencer_if.sv
// Bus bundle between the ROM download sequencer and its environment
// (HPS download stream, CPU read port, BRAM port, core status).
// slave  : the sequencer side.  master : the environment side (source, CPU, BRAM).
// Optional dl_sum checksum port exists only with ROM_DL_CHECKSUM_EN defined.
interface rom_dl_sequencer_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  // download stream
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic          dl_wait;
  // CPU read path
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rd_data;
  // BRAM port
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_wdata;
  logic          rom_we;
  logic [DW-1:0] rom_q;
  // status
  logic          core_reset;
  logic          rom_valid;
  logic          dl_dropped;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0]   dl_sum;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data, cpu_req, cpu_addr, rom_q,
    output dl_wait, cpu_ack, cpu_rd_data, rom_addr, rom_wdata, rom_we,
    output core_reset, rom_valid, dl_dropped, dl_sum
  );
  modport master (
    output dl_active, dl_wr, dl_addr, dl_data, cpu_req, cpu_addr, rom_q,
    input  dl_wait, cpu_ack, cpu_rd_data, rom_addr, rom_wdata, rom_we,
    input  core_reset, rom_valid, dl_dropped, dl_sum
  );
`else
  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data, cpu_req, cpu_addr, rom_q,
    output dl_wait, cpu_ack, cpu_rd_data, rom_addr, rom_wdata, rom_we,
    output core_reset, rom_valid, dl_dropped
  );
  modport master (
    output dl_active, dl_wr, dl_addr, dl_data, cpu_req, cpu_addr, rom_q,
    input  dl_wait, cpu_ack, cpu_rd_data, rom_addr, rom_wdata, rom_we,
    input  core_reset, rom_valid, dl_dropped
  );
`endif
endinterface

// File: rtl/rom_dl_sequencer.sv
// Sequences a ROM download into the single-port BRAM, owns core reset, then serves CPU reads.
// Latency: download byte -> BRAM write 1 cycle (unstalled); cpu_req -> cpu_ack 2 cycles.
// Backpressure: a byte arriving while the write buffer is full is parked; dl_wait stays high until both entries drain.
// Ports: clk_i, rst_i (async active-high); bus (rom_dl_sequencer_if.slave) carries
// download stream, CPU read port, BRAM port and core_reset/rom_valid/dl_dropped.
// Optional: ROM_DL_CHECKSUM_EN adds bus.dl_sum, 16-bit wrap sum of bytes written to BRAM.
module rom_dl_sequencer #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int ROM_DEPTH = 16384,
  parameter int RST_HOLD  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rom_dl_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_e;

  localparam int              CW        = $clog2(RST_HOLD + 1);
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(ROM_DEPTH);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(RST_HOLD - 1);

  state_e        state_q, state_d;
  // s_*: write stage feeding the BRAM; h_*: holding register for a byte that arrives while s_* is busy
  logic          s_vld_q, s_vld_d, h_vld_q, h_vld_d;
  logic [AW-1:0] s_addr_q, s_addr_d, h_addr_q, h_addr_d;
  logic [DW-1:0] s_dat_q, s_dat_d, h_dat_q, h_dat_d;
  logic          wait_q, wait_d;
  logic          nz_q, nz_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, ack_q, ack_d;
  logic [DW-1:0] rd_q, rd_d;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0]   sum_q, sum_d;
`endif

  logic run_now, in_range, accept;

  always_comb begin
    // RUN with dl_active high is already the hand-over cycle back to LOAD
    run_now  = (state_q == RUN) && !bus.dl_active;
    in_range = ({1'b0, bus.dl_addr} < DEPTH_W);
    accept   = (state_q == LOAD) && bus.dl_wr && in_range;

    state_d  = state_q;
    s_vld_d  = s_vld_q;
    s_addr_d = s_addr_q;
    s_dat_d  = s_dat_q;
    h_vld_d  = h_vld_q;
    h_addr_d = h_addr_q;
    h_dat_d  = h_dat_q;
    nz_d     = nz_q;
    drop_d   = drop_q;
    cnt_d    = '0;

    case (state_q)
      IDLE: begin
        if (bus.dl_active) begin
          state_d = LOAD;
          nz_d    = 1'b0;
          drop_d  = 1'b0;
        end
      end
      LOAD: begin
        if (h_vld_q) begin
          // parked byte moves up; a new arrival takes its place
          s_vld_d  = 1'b1;
          s_addr_d = h_addr_q;
          s_dat_d  = h_dat_q;
          h_vld_d  = accept;
          h_addr_d = bus.dl_addr;
          h_dat_d  = bus.dl_data;
        end else if (s_vld_q) begin
          // stage is being written this cycle, so an arrival is parked
          s_vld_d  = 1'b0;
          h_vld_d  = accept;
          h_addr_d = bus.dl_addr;
          h_dat_d  = bus.dl_data;
        end else begin
          s_vld_d  = accept;
          s_addr_d = bus.dl_addr;
          s_dat_d  = bus.dl_data;
        end
        if (accept && (bus.dl_data != '0)) nz_d = 1'b1;
        if (bus.dl_wr && !in_range)        drop_d = 1'b1;
        // leave only once every accepted byte has reached the BRAM
        if (!bus.dl_active && !s_vld_d && !h_vld_d) state_d = SETTLE;
      end
      SETTLE: begin
        if (bus.dl_active) begin
          state_d = LOAD;
          nz_d    = 1'b0;
          drop_d  = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = nz_q ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (bus.dl_active) begin
          state_d = LOAD;
          nz_d    = 1'b0;
          drop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    wait_d = h_vld_d || (wait_q && s_vld_d);

    // read pipeline; any stage is squashed when RUN is left
    req_d = bus.cpu_req && run_now;
    ack_d = req_q && run_now;
    rd_d  = ack_d ? bus.rom_q : '0;

`ifdef ROM_DL_CHECKSUM_EN
    sum_d = sum_q;
    if ((state_q != LOAD) && (state_d == LOAD)) sum_d = '0;
    else if ((state_q == LOAD) && s_vld_q)      sum_d = sum_q + 16'(s_dat_q);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      s_vld_q  <= 1'b0;
      s_addr_q <= '0;
      s_dat_q  <= '0;
      h_vld_q  <= 1'b0;
      h_addr_q <= '0;
      h_dat_q  <= '0;
      wait_q   <= 1'b0;
      nz_q     <= 1'b0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      rd_q     <= '0;
`ifdef ROM_DL_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      s_vld_q  <= s_vld_d;
      s_addr_q <= s_addr_d;
      s_dat_q  <= s_dat_d;
      h_vld_q  <= h_vld_d;
      h_addr_q <= h_addr_d;
      h_dat_q  <= h_dat_d;
      wait_q   <= wait_d;
      nz_q     <= nz_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ack_q    <= ack_d;
      rd_q     <= rd_d;
`ifdef ROM_DL_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign bus.dl_wait     = wait_q;
  assign bus.cpu_ack     = ack_q && run_now;
  assign bus.cpu_rd_data = (ack_q && run_now) ? rd_q : '0;
  assign bus.rom_addr    = (state_q == RUN) ? bus.cpu_addr : s_addr_q;
  assign bus.rom_wdata   = s_dat_q;
  assign bus.rom_we      = (state_q == LOAD) && s_vld_q;
  assign bus.core_reset  = !run_now;
  assign bus.rom_valid   = run_now;
  assign bus.dl_dropped  = drop_q;
`ifdef ROM_DL_CHECKSUM_EN
  assign bus.dl_sum      = sum_q;
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
module tb_rom_dl_sequencer;
  localparam int AW        = 14;
  localparam int DW        = 8;
  localparam int ROM_DEPTH = 12288;
  localparam int RST_HOLD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rom_dl_sequencer_if #(.AW(AW), .DW(DW)) bif();

  rom_dl_sequencer #(.AW(AW), .DW(DW), .ROM_DEPTH(ROM_DEPTH), .RST_HOLD(RST_HOLD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // BRAM with one cycle registered read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bif.rom_we) mem[bif.rom_addr] <= bif.rom_wdata;
    bif.rom_q <= mem[bif.rom_addr];
  end

  logic [7:0] img [4];
  logic [7:0] stall_dat [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.dl_active = 1'b0;
    bif.dl_wr     = 1'b0;
    bif.dl_addr   = '0;
    bif.dl_data   = '0;
    bif.cpu_req   = 1'b0;
    bif.cpu_addr  = '0;
  endtask

  task automatic test_reset();
    int bad_ack, bad_rst, bad_vld;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (bif.core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got=%b exp=1", bif.core_reset); end
    checks++; if (bif.rom_valid !== 1'b0) begin errors++; $display("FAIL rst_rom_valid got=%b exp=0", bif.rom_valid); end
    checks++; if (bif.dl_wait !== 1'b0) begin errors++; $display("FAIL rst_dl_wait got=%b exp=0", bif.dl_wait); end
    checks++; if (bif.rom_we !== 1'b0) begin errors++; $display("FAIL rst_rom_we got=%b exp=0", bif.rom_we); end
    checks++; if (bif.cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack got=%b exp=0", bif.cpu_ack); end
    checks++; if (bif.cpu_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got=%h exp=00", bif.cpu_rd_data); end
    checks++; if (bif.dl_dropped !== 1'b0) begin errors++; $display("FAIL rst_dl_dropped got=%b exp=0", bif.dl_dropped); end
`ifdef ROM_DL_CHECKSUM_EN
    checks++; if (bif.dl_sum !== 16'h0000) begin errors++; $display("FAIL rst_dl_sum got=%h exp=0000", bif.dl_sum); end
`endif
    rst = 1'b0;
    bad_ack = 0; bad_rst = 0; bad_vld = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bif.cpu_req  = 1'b1;
      bif.cpu_addr = AW'(i);
      #1;
      if (bif.cpu_ack !== 1'b0)    bad_ack++;
      if (bif.core_reset !== 1'b1) bad_rst++;
      if (bif.rom_valid !== 1'b0)  bad_vld++;
    end
    bif.cpu_req = 1'b0;
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL idle_no_ack got=%0d acked cycles exp=0", bad_ack); end
    checks++; if (bad_rst != 0) begin errors++; $display("FAIL idle_core_reset got=%0d low cycles exp=0", bad_rst); end
    checks++; if (bad_vld != 0) begin errors++; $display("FAIL idle_rom_valid got=%0d high cycles exp=0", bad_vld); end
  endtask

  task automatic test_load();
    img[0] = 8'h3E; img[1] = 8'h00; img[2] = 8'hC3; img[3] = 8'h12;
    tick();
    bif.dl_active = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bif.dl_wr = 1'b1; bif.dl_addr = AW'(i); bif.dl_data = img[i];
      #1;
      checks++; if (bif.rom_we !== 1'b0) begin errors++; $display("FAIL load_we_early[%0d] got=%b exp=0", i, bif.rom_we); end
      tick();
      bif.dl_wr = 1'b0;
      if (i == 3) bif.dl_active = 1'b0;
      #1;
      checks++;
      if (bif.rom_we !== 1'b1 || bif.rom_addr !== AW'(i) || bif.rom_wdata !== img[i] || bif.core_reset !== 1'b1) begin
        errors++;
        $display("FAIL load_write[%0d] got we=%b addr=%h data=%h crst=%b exp we=1 addr=%h data=%h crst=1",
                 i, bif.rom_we, bif.rom_addr, bif.rom_wdata, bif.core_reset, i, img[i]);
      end
    end
    for (int k = 0; k < RST_HOLD; k++) begin
      tick();
      checks++;
      if (bif.core_reset !== 1'b1 || bif.rom_valid !== 1'b0) begin
        errors++;
        $display("FAIL settle_hold[%0d] got crst=%b valid=%b exp crst=1 valid=0", k, bif.core_reset, bif.rom_valid);
      end
    end
    tick();
    checks++; if (bif.core_reset !== 1'b0) begin errors++; $display("FAIL run_core_reset got=%b exp=0", bif.core_reset); end
    checks++; if (bif.rom_valid !== 1'b1) begin errors++; $display("FAIL run_rom_valid got=%b exp=1", bif.rom_valid); end
    checks++; if (bif.dl_dropped !== 1'b0) begin errors++; $display("FAIL load_dropped got=%b exp=0", bif.dl_dropped); end
`ifdef ROM_DL_CHECKSUM_EN
    checks++; if (bif.dl_sum !== 16'h0113) begin errors++; $display("FAIL load_sum got=%h exp=0113", bif.dl_sum); end
`endif
  endtask

  task automatic test_run_read();
    tick();
    bif.cpu_req = 1'b1; bif.cpu_addr = AW'(2);
    #1;
    checks++; if (bif.rom_addr !== AW'(2)) begin errors++; $display("FAIL rd_rom_addr got=%h exp=0002", bif.rom_addr); end
    tick();
    bif.cpu_req = 1'b0;
    #1;
    checks++; if (bif.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_n1 got=%b exp=0", bif.cpu_ack); end
    tick();
    checks++;
    if (bif.cpu_ack !== 1'b1 || bif.cpu_rd_data !== 8'hC3) begin
      errors++; $display("FAIL rd_ack_n2 got ack=%b data=%h exp ack=1 data=c3", bif.cpu_ack, bif.cpu_rd_data);
    end
    tick();
    checks++;
    if (bif.cpu_ack !== 1'b0 || bif.cpu_rd_data !== 8'h00) begin
      errors++; $display("FAIL rd_ack_n3 got ack=%b data=%h exp ack=0 data=00", bif.cpu_ack, bif.cpu_rd_data);
    end
    // back-to-back reads of addresses 0..3
    for (int i = 0; i < 6; i++) begin
      logic          exp_ack;
      logic [DW-1:0] exp_dat;
      tick();
      bif.cpu_req  = (i < 4);
      bif.cpu_addr = AW'(i);
      #1;
      exp_ack = (i >= 2);
      exp_dat = (i >= 2) ? img[i-2] : 8'h00;
      checks++;
      if (bif.cpu_ack !== exp_ack || bif.cpu_rd_data !== exp_dat) begin
        errors++; $display("FAIL b2b_read[%0d] got ack=%b data=%h exp ack=%b data=%h", i, bif.cpu_ack, bif.cpu_rd_data, exp_ack, exp_dat);
      end
    end
    bif.cpu_req = 1'b0;
    // download rising one cycle after a read request squashes the read
    tick();
    bif.cpu_req = 1'b1; bif.cpu_addr = AW'(2);
    #1;
    tick();
    bif.cpu_req = 1'b0; bif.dl_active = 1'b1;
    #1;
    checks++;
    if (bif.core_reset !== 1'b1 || bif.rom_valid !== 1'b0 || bif.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL abort_n1 got crst=%b valid=%b ack=%b exp crst=1 valid=0 ack=0", bif.core_reset, bif.rom_valid, bif.cpu_ack);
    end
    tick();
    checks++;
    if (bif.cpu_ack !== 1'b0 || bif.cpu_rd_data !== 8'h00) begin
      errors++; $display("FAIL abort_n2 got ack=%b data=%h exp ack=0 data=00", bif.cpu_ack, bif.cpu_rd_data);
    end
  endtask

  // continues in LOAD from the aborted read: only zero bytes are loaded
  task automatic test_zero_load();
    int bad;
    for (int i = 0; i < 2; i++) begin
      tick();
      bif.dl_wr = 1'b1; bif.dl_addr = AW'(4 + i); bif.dl_data = 8'h00;
      #1;
      tick();
      bif.dl_wr = 1'b0;
      if (i == 1) bif.dl_active = 1'b0;
      #1;
      checks++;
      if (bif.rom_we !== 1'b1 || bif.rom_addr !== AW'(4 + i) || bif.rom_wdata !== 8'h00) begin
        errors++; $display("FAIL zero_write[%0d] got we=%b addr=%h data=%h exp we=1 addr=%h data=00", i, bif.rom_we, bif.rom_addr, bif.rom_wdata, 4 + i);
      end
    end
    bad = 0;
    for (int k = 0; k < RST_HOLD + 8; k++) begin
      tick();
      bif.cpu_req = 1'b1; bif.cpu_addr = AW'(2);
      #1;
      if (bif.core_reset !== 1'b1 || bif.rom_valid !== 1'b0 || bif.cpu_ack !== 1'b0) bad++;
    end
    bif.cpu_req = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_load_idle got=%0d bad cycles exp=0", bad); end
`ifdef ROM_DL_CHECKSUM_EN
    checks++; if (bif.dl_sum !== 16'h0000) begin errors++; $display("FAIL zero_sum got=%h exp=0000", bif.dl_sum); end
`endif
  endtask

  task automatic test_back_to_back();
    logic        wr_t   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        we_t   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        wait_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int          widx   [6] = '{0, 0, 0, 1, 2, 0};
    stall_dat[0] = 8'h11; stall_dat[1] = 8'h22; stall_dat[2] = 8'h33;
    tick();
    bif.dl_active = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      tick();
      bif.dl_active = (j < 4);
      bif.dl_wr     = wr_t[j];
      bif.dl_addr   = AW'(10 + (j < 3 ? j : 0));
      bif.dl_data   = (j < 3) ? stall_dat[j] : 8'h00;
      #1;
      checks++;
      if (bif.dl_wait !== wait_t[j]) begin
        errors++; $display("FAIL stall_wait[%0d] got=%b exp=%b", j, bif.dl_wait, wait_t[j]);
      end
      checks++;
      if (bif.rom_we !== we_t[j] ||
          (we_t[j] && (bif.rom_addr !== AW'(10 + widx[j]) || bif.rom_wdata !== stall_dat[widx[j]]))) begin
        errors++; $display("FAIL stall_write[%0d] got we=%b addr=%h data=%h exp we=%b addr=%h data=%h",
                           j, bif.rom_we, bif.rom_addr, bif.rom_wdata, we_t[j], 10 + widx[j], stall_dat[widx[j]]);
      end
    end
    bif.dl_wr = 1'b0;
    for (int k = 0; k < RST_HOLD - 1; k++) tick();
    tick();
    checks++; if (bif.rom_valid !== 1'b1) begin errors++; $display("FAIL stall_run got valid=%b exp=1", bif.rom_valid); end
    // read back all three bytes to confirm order and that none was lost
    for (int k = 0; k < 5; k++) begin
      tick();
      bif.cpu_req  = (k < 3);
      bif.cpu_addr = AW'(10 + k);
      #1;
      if (k >= 2) begin
        checks++;
        if (bif.cpu_ack !== 1'b1 || bif.cpu_rd_data !== stall_dat[k-2]) begin
          errors++; $display("FAIL stall_readback[%0d] got ack=%b data=%h exp ack=1 data=%h", k - 2, bif.cpu_ack, bif.cpu_rd_data, stall_dat[k-2]);
        end
      end
    end
    bif.cpu_req = 1'b0;
  endtask

  task automatic test_drop();
    tick();
    bif.dl_active = 1'b1;
    #1;
    tick();
    bif.dl_wr = 1'b1; bif.dl_addr = 14'h3FFF; bif.dl_data = 8'h55;
    #1;
    tick();
    bif.dl_wr = 1'b0;
    #1;
    checks++; if (bif.rom_we !== 1'b0) begin errors++; $display("FAIL drop_no_we got=%b exp=0", bif.rom_we); end
    checks++; if (bif.dl_dropped !== 1'b1) begin errors++; $display("FAIL drop_flag got=%b exp=1", bif.dl_dropped); end
    tick();
    bif.dl_wr = 1'b1; bif.dl_addr = AW'(20); bif.dl_data = 8'h07;
    #1;
    tick();
    bif.dl_wr = 1'b0; bif.dl_active = 1'b0;
    #1;
    checks++;
    if (bif.rom_we !== 1'b1 || bif.rom_addr !== AW'(20) || bif.rom_wdata !== 8'h07) begin
      errors++; $display("FAIL drop_good_write got we=%b addr=%h data=%h exp we=1 addr=0014 data=07", bif.rom_we, bif.rom_addr, bif.rom_wdata);
    end
    repeat (RST_HOLD + 1) tick();
    checks++; if (bif.rom_valid !== 1'b1) begin errors++; $display("FAIL drop_valid got=%b exp=1", bif.rom_valid); end
    checks++; if (bif.dl_dropped !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", bif.dl_dropped); end
`ifdef ROM_DL_CHECKSUM_EN
    checks++; if (bif.dl_sum !== 16'h0007) begin errors++; $display("FAIL drop_sum got=%h exp=0007", bif.dl_sum); end
`endif
  endtask

  task automatic test_reset_mid_load();
    int bad;
    tick();
    bif.dl_active = 1'b1;
    #1;
    tick();
    bif.dl_wr = 1'b1; bif.dl_addr = AW'(30); bif.dl_data = 8'h09;
    #1;
    tick();
    bif.dl_wr = 1'b0;
    #1;
    checks++; if (bif.rom_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got=%b exp=1", bif.rom_we); end
    rst = 1'b1;
    #1;
    checks++;
    if (bif.rom_we !== 1'b0 || bif.core_reset !== 1'b1 || bif.rom_valid !== 1'b0 || bif.dl_wait !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got we=%b crst=%b valid=%b wait=%b exp we=0 crst=1 valid=0 wait=0",
                         bif.rom_we, bif.core_reset, bif.rom_valid, bif.dl_wait);
    end
    bif.dl_active = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < RST_HOLD + 6; k++) begin
      tick();
      bif.cpu_req = 1'b1; bif.cpu_addr = AW'(0);
      #1;
      if (bif.core_reset !== 1'b1 || bif.cpu_ack !== 1'b0) bad++;
    end
    bif.cpu_req = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_idle got=%0d bad cycles exp=0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_run_read();
    test_zero_load();
    test_back_to_back();
    test_drop();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sequences the ROM download into the core's single-port program/graphics BRAM, then hands the BRAM over to the CPU read path.
- Owns the core reset: the core is held in reset until a download containing at least one non-zero byte completes, plus a settle period.
- Sits between the HPS ioctl download stream (index 0 already qualified upstream) and the game core's ROM port, replacing the ad-hoc reset/latch logic in the top level.

Parameters:
- AW, 14, BRAM address width; the download stream and CPU addresses are also AW bits.
- DW, 8, data width.
- ROM_DEPTH, 16384, number of valid BRAM locations; must be <= 2^AW.
- RST_HOLD, 16, number of clk cycles core_reset stays high after the download ends; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dl_active  in  1  download of ROM index in progress (level)
- dl_wr  in  1  one-cycle strobe; dl_addr/dl_data valid
- dl_addr  in  AW  download byte address
- dl_data  in  DW  download byte
- dl_wait  out  1  stall request to the download source
- cpu_req  in  1  one-cycle CPU read request
- cpu_addr  in  AW  CPU read address
- cpu_ack  out  1  read data valid strobe
- cpu_rd_data  out  DW  read data
- rom_addr  out  AW  BRAM address
- rom_wdata  out  DW  BRAM write data
- rom_we  out  1  BRAM write enable
- rom_q  in  DW  BRAM read data (1-cycle registered latency)
- core_reset  out  1  reset to the game core
- rom_valid  out  1  a valid image is loaded
- dl_dropped  out  1  sticky flag: an out-of-range byte was discarded during the last load

Behaviour:
- Reset values: state IDLE, core_reset=1, rom_valid=0, dl_wait=0, rom_we=0, cpu_ack=0, cpu_rd_data=0, dl_dropped=0, write buffer empty, nonzero_seen=0, hold counter=0.
- States: IDLE (no image), LOAD, SETTLE, RUN.
- IDLE:
  - core_reset=1.
  - On dl_active=1, go to LOAD and clear nonzero_seen, dl_dropped and rom_valid.
- LOAD:
  - core_reset=1.
  - One-entry write buffer: dl_wr with dl_addr < ROM_DEPTH loads the buffer. The next cycle drives rom_we=1 with rom_addr/rom_wdata from the buffer, and the buffer drains.
  - Write latency is 1 cycle.
  - If dl_wr arrives while the buffer is full, the new byte is taken into a second holding register and dl_wait=1 until both entries drain. No byte is lost.
  - dl_addr >= ROM_DEPTH: the byte is not written and dl_dropped is set.
  - Any accepted dl_data != 0 sets nonzero_seen.
  - On dl_active falling, go to SETTLE once the buffer is empty. Pending writes always complete first.
- SETTLE:
  - core_reset=1; the hold counter counts up from 0.
  - When the counter reaches RST_HOLD-1: if nonzero_seen, go to RUN and set rom_valid=1; otherwise go to IDLE.
  - dl_active=1 during SETTLE restarts LOAD.
- RUN:
  - core_reset=0, rom_valid=1.
  - rom_addr = cpu_addr combinationally, rom_we=0.
  - cpu_req in cycle N gives cpu_ack=1 and cpu_rd_data=rom_q in cycle N+2: one cycle of BRAM latency plus one output register.
  - Back-to-back requests are allowed, one per cycle, fully pipelined.
  - dl_active=1 goes to LOAD in the same cycle. core_reset rises in that cycle, rom_valid drops, and in-flight acks are suppressed.
- Outside RUN: cpu_req is ignored, cpu_ack=0, cpu_rd_data=0.
- Simultaneous dl_active rise and cpu_req in RUN: the download wins and the read is never acked.
- dl_wr outside LOAD is ignored.
- reset asserted mid-LOAD: immediate return to IDLE; the BRAM contents are left as written.

Optional Feature:
- Macro: ROM_DL_CHECKSUM_EN.
- With the macro defined:
  - Adds output dl_sum[15:0], the 16-bit wrap-around sum of all accepted in-range bytes.
  - dl_sum is cleared on entry to LOAD, updated on each BRAM write, and held thereafter. Reset value is 0.
- Without the macro: the port and adder are absent; behaviour is otherwise identical.

Test Plan:
- No download after reset -> core_reset=1, rom_valid=0 indefinitely; cpu_req never acked.
- Load 4 bytes {0x3E,0x00,0xC3,0x12} at addresses 0..3, then drop dl_active -> four rom_we pulses with matching addr/data. core_reset falls exactly RST_HOLD cycles after the buffer empties; rom_valid=1.
- Load of all-zero bytes -> ends in IDLE, core_reset stays 1, rom_valid=0.
- dl_wr on two consecutive cycles plus a third while full -> dl_wait=1 for the stalled cycles; all 3 bytes are written in order, none lost.
- dl_addr=0x3FFF with ROM_DEPTH=0x3000 -> no rom_we, dl_dropped=1; the image is still valid if a non-zero byte was seen.
- RUN: cpu_req at addr 2 in cycle N -> cpu_ack and cpu_rd_data=0xC3 in cycle N+2. dl_active rising in cycle N+1 -> no ack, core_reset=1 in cycle N+1.
